// File: rtl/vga_pixel_clk_gen.sv
// Pixel-clock generator: divides the 100 MHz system clock by a per-resolution half-period.
// Define VGA_CLK_GEN_GATE_EN to hold clk_o low until the new rate is locked.

package vga_pkg;
  typedef enum logic [1:0] {
    VGA_RES_640_480   = 2'd0,
    VGA_RES_800_600   = 2'd1,
    VGA_RES_1280_1024 = 2'd2
  } vga_resolution_e;
endpackage

module vga_pixel_clk_gen
  import vga_pkg::*;
#(
  parameter int HALF_640    = 2,
  parameter int HALF_800    = 1,
  parameter int HALF_1280   = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic            clk_100m_i,
  input  logic            arstn_i,
  input  vga_resolution_e resolution_i,
  input  logic            req_i,
  output logic            clk_o,
  output logic            valid_o
);

  localparam int HALF_MAX_A = (HALF_640 > HALF_800) ? HALF_640 : HALF_800;
  localparam int HALF_MAX   = (HALF_MAX_A > HALF_1280) ? HALF_MAX_A : HALF_1280;
  localparam int DIV_W      = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int LOCK_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  H640_M1  = DIV_W'(HALF_640 - 1);
  localparam logic [DIV_W-1:0]  H800_M1  = DIV_W'(HALF_800 - 1);
  localparam logic [DIV_W-1:0]  H1280_M1 = DIV_W'(HALF_1280 - 1);
  localparam logic [LOCK_W-1:0] LOCK_M1  = LOCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e            state;
  vga_resolution_e   res_latched;
  logic [DIV_W-1:0]  div_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              phase;

  logic [DIV_W-1:0]  half_m1;
  logic              wrap;
  logic [DIV_W-1:0]  div_cnt_next;
  logic              phase_next;

  always_comb begin
    half_m1 = H640_M1;
    case (res_latched)
      VGA_RES_640_480:   half_m1 = H640_M1;
      VGA_RES_800_600:   half_m1 = H800_M1;
      VGA_RES_1280_1024: half_m1 = H1280_M1;
      default:           half_m1 = H640_M1;
    endcase
    wrap         = (div_cnt == half_m1);
    div_cnt_next = wrap ? '0 : div_cnt + DIV_W'(1);
    phase_next   = phase ^ wrap;
  end

  // phase is the free-running divider output; clk_o is its (optionally gated) registered copy.
  always_ff @(posedge clk_100m_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      res_latched <= VGA_RES_640_480;
      div_cnt     <= '0;
      lock_cnt    <= '0;
      phase       <= 1'b0;
      clk_o       <= 1'b0;
      valid_o     <= 1'b0;
    end else if (req_i && (state != SETTLE)) begin
      state       <= SETTLE;
      res_latched <= resolution_i;
      div_cnt     <= '0;
      lock_cnt    <= LOCK_M1;
      phase       <= 1'b0;
      clk_o       <= 1'b0;
      valid_o     <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          div_cnt <= div_cnt_next;
          phase   <= phase_next;
          if (lock_cnt == '0) begin
            state   <= LOCKED;
            valid_o <= 1'b1;
            clk_o   <= phase_next;
          end else begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
`ifdef VGA_CLK_GEN_GATE_EN
            clk_o    <= 1'b0;
`else
            clk_o    <= phase_next;
`endif
          end
        end
        LOCKED: begin
          div_cnt <= div_cnt_next;
          phase   <= phase_next;
          clk_o   <= phase_next;
        end
        default: begin
          state   <= IDLE;
          div_cnt <= '0;
          phase   <= 1'b0;
          clk_o   <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_clk_gen.sv
// Directed bench for vga_pixel_clk_gen: reset, mode lock/period per resolution, busy requests, reset abort.
// Inputs are driven and outputs sampled on the falling edge.

module tb_vga_pixel_clk_gen;
  import vga_pkg::*;

  localparam int LOCK = 16;
`ifdef VGA_CLK_GEN_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic            clk;
  logic            arstn;
  vga_resolution_e resolution;
  logic            req;
  logic            pix_clk;
  logic            valid;

  int n_checks = 0;
  int n_pass   = 0;

  vga_pixel_clk_gen #(
    .HALF_640(2), .HALF_800(1), .HALF_1280(1), .LOCK_CYCLES(LOCK)
  ) dut (
    .clk_100m_i  (clk),
    .arstn_i     (arstn),
    .resolution_i(resolution),
    .req_i       (req),
    .clk_o       (pix_clk),
    .valid_o     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Accept a mode at the next edge (E0), then check both outputs for LOCK+4 edges.
  // Optionally pulse a conflicting request during SETTLE, which must be ignored.
  task automatic run_mode(input vga_resolution_e res, input int h, input string tag, input int busy_at);
    int exp_clk;
    vga_resolution_e other;
    other      = (res == VGA_RES_1280_1024) ? VGA_RES_640_480 : VGA_RES_1280_1024;
    req        = 1'b1;
    resolution = res;
    @(negedge clk);
    check({tag, " k0 clk"}, 32'(pix_clk), 0);
    check({tag, " k0 valid"}, 32'(valid), 0);
    req        = 1'b0;
    resolution = other;
    for (int k = 1; k <= LOCK + 4; k++) begin
      @(negedge clk);
      exp_clk = (GATED && k < LOCK) ? 0 : (k / h) % 2;
      check($sformatf("%s k%0d clk", tag, k), 32'(pix_clk), 32'(exp_clk));
      check($sformatf("%s k%0d valid", tag, k), 32'(valid), (k >= LOCK) ? 1 : 0);
      req = (k == busy_at);
    end
    req = 1'b0;
    $display("mode %s: half=%0d done, %0d/%0d so far", tag, h, n_pass, n_checks);
  endtask

  initial begin
    arstn      = 1'b0;
    req        = 1'b1;
    resolution = VGA_RES_1280_1024;

    // Reset holds everything low despite a pending request.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("rst c%0d clk", i), 32'(pix_clk), 0);
      check($sformatf("rst c%0d valid", i), 32'(valid), 0);
    end
    $display("reset: 10 cycles checked");

    // First edge with reset released accepts the still-high request.
    arstn = 1'b1;
    run_mode(VGA_RES_1280_1024, 1, "r1280", 0);
    run_mode(VGA_RES_800_600,   1, "r800",  0);
    run_mode(VGA_RES_640_480,   2, "r640",  0);
    run_mode(VGA_RES_640_480,   2, "busy",  5);
    run_mode(vga_resolution_e'(2'd3), 2, "rbad", 0);

    // Reset 5 edges into SETTLE of an 800x600 request (clk_o would be 1 otherwise).
    req        = 1'b1;
    resolution = VGA_RES_800_600;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    arstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort c%0d clk", i), 32'(pix_clk), 0);
      check($sformatf("abort c%0d valid", i), 32'(valid), 0);
    end
    arstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("idle c%0d clk", i), 32'(pix_clk), 0);
      check($sformatf("idle c%0d valid", i), 32'(valid), 0);
    end
    $display("reset abort: block idle afterwards");

    run_mode(VGA_RES_800_600, 1, "recover", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_clk_gen.md
# vga_pixel_clk_gen

Pixel-clock generator for the VGA controller: derives the pixel clock `clk_o` from the 100 MHz system clock with a programmable integer divider selected by the requested resolution. A level request/valid handshake reconfigures it. `valid_o` tells downstream timing logic when the clock is stable at the new rate. It sits between the board clock and the VGA sync/pixel pipeline.

## Interface
Parameters:
- `HALF_640` (default 2): half-period of `clk_o` in `clk_100m_i` cycles for `VGA_RES_640_480`, giving 25 MHz.
- `HALF_800` (default 1): half-period for `VGA_RES_800_600`, giving 50 MHz (800x600@72).
- `HALF_1280` (default 1): half-period for `VGA_RES_1280_1024`, giving 50 MHz. This is the maximum achievable rate.
- `LOCK_CYCLES` (default 16): input cycles from request acceptance to `valid_o`. Must be ≥1.

Ports:
- `clk_100m_i`  in  1: 100 MHz system clock. One clock; all logic is on its rising edge.
- `arstn_i`  in  1: reset, synchronous, active-low.
- `resolution_i`  in  `vga_pkg::vga_resolution_e`: requested mode; sampled only when a request is accepted.
- `req_i`  in  1: reconfiguration request (level).
- `clk_o`  out  1: generated pixel clock (registered, 50% duty).
- `valid_o`  out  1: `clk_o` is running at the latched resolution's rate.

## Operation
- Half-period `H` is selected from the latched resolution: `VGA_RES_640_480`→`HALF_640`, `VGA_RES_800_600`→`HALF_800`, `VGA_RES_1280_1024`→`HALF_1280`. Any other encoding uses `HALF_640`.
- States:
  - IDLE: after reset. `clk_o` is 0 and `valid_o` is 0.
  - SETTLE: divider running, lock counter counting.
  - LOCKED: `valid_o` is 1.
- Acceptance: `req_i`=1 sampled in IDLE or LOCKED. On acceptance:
  - latch `resolution_i`;
  - clear the divider counter, `clk_o` and `valid_o`;
  - load the lock counter;
  - go to SETTLE.
- `req_i` is ignored in SETTLE. A request held high through LOCKED is re-accepted on the next edge, so the requester drops `req_i` once it sees `valid_o`.
- SETTLE→LOCKED when the lock counter expires, `LOCK_CYCLES` edges after acceptance.
- Divider in SETTLE/LOCKED: the counter increments each cycle. At `H-1` it wraps to 0 and `clk_o` toggles.
- Counter widths are sized for the largest half-period parameter and for `LOCK_CYCLES`, with no overflow.

## Timing
- Reset, sampled at an edge: the next state is IDLE, and `clk_o`, `valid_o` and all counters are 0. Reset has priority over `req_i`. Reset mid-SETTLE or mid-LOCKED aborts immediately.
- Let E0 be the accepting edge:
  - `valid_o`=0 and `clk_o`=0 after E0.
  - `clk_o` toggles after edges E0+H, E0+2H, …
  - `valid_o`=1 after edge E0+`LOCK_CYCLES`.
- With `req_i` sampled high in LOCKED at edge E0, `valid_o` falls after E0. The low period is exactly `LOCK_CYCLES` cycles.
- Output period is 2·H input cycles, so 20 ns·H.

## Configuration
- `VGA_CLK_GEN_GATE_EN` defined: `clk_o` is forced to 0 whenever `valid_o`=0, i.e. in SETTLE. The divider still runs internally, so phase is identical once `valid_o` rises.
- Not defined: `clk_o` toggles through SETTLE as described in Timing.

## Test plan
- Reset: `arstn_i`=0 for 10 cycles with `req_i`=1 → `clk_o`=0, `valid_o`=0 throughout. The first acceptance happens at the first edge with `arstn_i`=1.
- 1280x1024 request: `req_i`=1, `VGA_RES_1280_1024` → `valid_o` rises 16 cycles after acceptance. `clk_o` period is 20 ns (50 MHz). Drop `req_i` → `valid_o` stays 1.
- Switch to 800x600: after a lock, `req_i` low for one cycle, then `req_i`=1 with `VGA_RES_800_600` → `valid_o` falls on the next edge, is low for 16 cycles, then rises. `clk_o` period is 20 ns.
- 640x480: request `VGA_RES_640_480` → `clk_o` period is 40 ns with 50% duty, and `valid_o` rises after 16 cycles.
- Request while busy: pulse `req_i` with a different resolution during SETTLE → ignored. The originally latched rate and timing are preserved.
- Reset mid-SETTLE: assert reset 5 cycles after acceptance → `valid_o`/`clk_o` are 0 and the block returns to IDLE. Also check the gated variant: `clk_o` is flat during SETTLE.
